// File: rtl/cla_pkg.sv
// Shared defaults, derived sizes and FSM encoding for the digit-serial CLA arithmetic blocks.
package cla_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    // Slice counter needs at least one bit even when only one slice exists
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_SLICES = DEFAULT_WIDTH / DEFAULT_SLICE;
    localparam int CNT_W      = cnt_width(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice.sv
// Purely combinational SLICE-bit carry look-ahead unit: sum = x + y + cin.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   carry;
    logic             acc;
    logic             pp;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is the flat sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        pp       = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            carry[i+1] = acc | (pp & cin);
        end
    end

    assign sum  = p ^ carry[SLICE-1:0];
    assign cout = carry[SLICE];

endmodule

// File: rtl/cla_seq_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, one CLA slice per clock, LSB slice first.
module cla_seq_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int            NSLICES = WIDTH / SLICE;
    localparam int            KW      = cnt_width(NSLICES);
    localparam logic [KW-1:0] LAST_K  = KW'(NSLICES - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [WIDTH-1:0] diff_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             bout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sl_sum;
    logic             sl_cout;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICES; i++) begin
            if (int'(k_q) == i) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = nb_q[i*SLICE +: SLICE];
            end
        end
    end

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x    (a_sl),
        .y    (b_sl),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Subtraction is a + ~b + ~bin, so b and bin are stored inverted at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        nb_q       <= ~b;
                        carry_q    <= ~bin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NSLICES; i++) begin
                        if (int'(k_q) == i) begin
                            diff_q[i*SLICE +: SLICE] <= sl_sum;
                        end
                    end
                    carry_q <= sl_cout;
                    if (k_q == LAST_K) begin
                        // Operand signs differ exactly when a and ~b share their MSB
                        bout_q      <= ~sl_cout;
                        ovf_q       <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                                       (sl_sum[SLICE-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Directed self-checking bench for cla_seq_subtractor with a short random tail.
module tb_cla_seq_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    cla_seq_subtractor #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one operand set for exactly one edge
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("accepted", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic runVector(input string tag, input logic [15:0] va, input logic [15:0] vb,
                             input logic vbin, input logic [15:0] ed, input logic eb,
                             input logic eo);
        applyStimulus(va, vb, vbin);
        tick();
        tick();
        tick();
        checkOutput({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_diff"}, {16'b0, diff}, {16'b0, ed});
        checkOutput({tag, "_bout"}, {31'b0, bout}, {31'b0, eb});
        checkOutput({tag, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_consumed"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        logic [16:0] full;
        logic        eovf;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_diff", {16'b0, diff}, 32'd0);
        checkOutput("rst_bout", {31'b0, bout}, 32'd0);
        checkOutput("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        runVector("v3m2", 16'd3, 16'd2, 1'b0, 16'd1, 1'b0, 1'b0);
        runVector("v2m3", 16'd2, 16'd3, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        runVector("v7m5b", 16'd7, 16'd5, 1'b1, 16'd1, 1'b0, 1'b0);
        runVector("vmin", 16'h8000, 16'd1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        runVector("vmax", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        runVector("vzero", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        runVector("vffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        runVector("vchain", 16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, 1'b0);

        // Backpressure with operands disturbed and a spurious in_valid during BUSY
        applyStimulus(16'd255, 16'd100, 1'b0);
        a        = 16'hAAAA;
        b        = 16'h5555;
        bin      = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_diff_hold", {16'b0, diff}, 32'd155);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_valid_hold", {31'b0, out_valid}, 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_consumed", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_ready_back", {31'b0, in_ready}, 32'd1);

        // Abort while slice 2 is the next slice to be processed
        applyStimulus(16'd1000, 16'd1, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_diff", {16'b0, diff}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        runVector("after_abort", 16'd50, 16'd30, 1'b0, 16'd20, 1'b0, 1'b0);

        // Random tail against an independent 17-bit arithmetic model
        for (int t = 0; t < 200; t++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
            eovf = (ra[15] != rb[15]) && (full[15] != ra[15]);
            applyStimulus(ra, rb, rbin);
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checkOutput("rnd_latency", n, 32'd4);
            checkOutput("rnd_diff", {16'b0, diff}, {16'b0, full[15:0]});
            checkOutput("rnd_bout", {31'b0, bout}, {31'b0, full[16]});
            checkOutput("rnd_ovf", {31'b0, overflow}, {31'b0, eovf});
            n = $urandom_range(0, 3);
            for (int s = 0; s < n; s++) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checkOutput("rnd_single", {31'b0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
